// File: rtl/sti_pixel_streamer_if.sv
// ROM read port and pixel stream grouped for the STI pixel streamer.
interface sti_pixel_streamer_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ROW_W  = 7,
  parameter int unsigned COL_W  = 7
);
  logic              sti_rd;
  logic [ADDR_W-1:0] sti_addr;
  logic [WORD_W-1:0] sti_di;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic [ROW_W-1:0]  pix_row;
  logic [COL_W-1:0]  pix_col;
  logic              pix_sof;
  logic              pix_eof;

  modport master (
    output sti_rd, sti_addr, pix_valid, pix_data, pix_row, pix_col, pix_sof, pix_eof,
    input  sti_di, pix_ready
  );

  modport slave (
    input  sti_rd, sti_addr, pix_valid, pix_data, pix_row, pix_col, pix_sof, pix_eof,
    output sti_di, pix_ready
  );
endinterface

// File: rtl/sti_pixel_streamer.sv
// Fetches packed binary image words from the stimulus ROM, buffers up to two
// words ahead and streams single-bit pixels in raster order with row/col and
// frame markers over a valid/ready handshake.
module sti_pixel_streamer #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  sti_pixel_streamer_if.master bus
);

  localparam int unsigned NWORDS = IMG_W * IMG_H / WORD_W;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned BIT_W  = $clog2(WORD_W);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [WORD_W-1:0] fifo_q [2];
  logic [WORD_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic              busy_w;
  logic              valid_w;
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              push;
  logic              pop;
  logic              issue;
  logic [WORD_W-1:0] head_shifted;

  // Handshake and unpack decode shared by the control and datapath processes.
  always_comb begin
    busy_w       = (state_q == S_RUN) || (state_q == S_DRAIN);
    valid_w      = busy_w && (cnt_q != 2'd0);
    accept       = valid_w && bus.pix_ready;
    last_col     = (col_q == LAST_COL);
    last_row     = (row_q == LAST_ROW);
    push         = rd_q;
    pop          = accept && (bit_q == LAST_BIT);
    head_shifted = fifo_q[rd_ptr_q] << bit_q;
  end

  // Frame FSM and ROM request generation; reads are throttled so that
  // buffered words plus the outstanding read never exceed two.
  always_comb begin
    state_d  = state_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    issued_d = issued_q;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          issue   = 1'b1;
        end
      end
      S_RUN:   issue = ((cnt_q + {1'b0, rd_q}) < 2'd2);
      S_DRAIN: if (accept && last_row && last_col) state_d = S_DONE;
      S_DONE: begin
        state_d  = S_IDLE;
        issued_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      rd_d     = 1'b1;
      addr_d   = issued_q[ADDR_W-1:0];
      issued_d = issued_q + 1'b1;
      if (issued_q == LAST_WORD) state_d = S_DRAIN;
    end
  end

  // Prefetch FIFO push/pop and bit/column/row advance on each acceptance.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    col_d    = col_q;
    row_d    = row_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.sti_di;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (accept) begin
      bit_d = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State, request and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      issued_q  <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  // Outputs are pure functions of registered state, so they hold while stalled.
  always_comb begin
    busy          = busy_w;
    done          = (state_q == S_DONE);
    bus.sti_rd    = rd_q;
    bus.sti_addr  = addr_q;
    bus.pix_valid = valid_w;
    bus.pix_data  = valid_w && head_shifted[WORD_W-1];
    bus.pix_row   = row_q;
    bus.pix_col   = col_q;
    bus.pix_sof   = valid_w && (row_q == '0) && (col_q == '0);
    bus.pix_eof   = valid_w && last_row && last_col;
  end

endmodule

// File: tb/tb_sti_pixel_streamer.sv
// Self-checking bench for sti_pixel_streamer: frame-level vector table plus a
// pixel scoreboard filled from a reference unpack of the ROM contents.
module tb_sti_pixel_streamer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  sti_pixel_streamer_if #(.WORD_W(16), .ADDR_W(10), .ROW_W(7), .COL_W(7)) bus ();

  sti_pixel_streamer #(.IMG_W(128), .IMG_H(128), .WORD_W(16), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pat;        // 0 all ones, 1 sparse markers, 2 random, 3 keep previous
    int rdy;        // 1 always ready, 3 pattern 1,0,0
    bit repulse;    // pulse start again at pixel 100 and 16000
    bit b2b;        // start in the cycle right after the previous done
    int abort_at;   // reset once this many pixels are accepted (0 = never)
    int exp_acc;
    int exp_rd;     // -1 = not checked
    int exp_done;
    int exp_first;  // first acceptance edge minus start edge, -1 = not checked
  } vec_t;

  typedef struct packed {
    logic       d;
    logic [6:0] r;
    logic [6:0] c;
    logic       sof;
    logic       eof;
  } pix_t;

  logic [15:0] rom [1024];
  pix_t        exp_q [$];
  vec_t        vecs [4];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0, rd_cnt = 0, done_cnt = 0, exp_addr = 0;
  int          first_acc_edge = -1, last_acc_edge = -1;
  int          rdy_mode = 1;
  bit          prev_stall = 1'b0;
  pix_t        prev_pix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_sti_rd"},   32'(bus.sti_rd), 0);
    chk({tag, "_sti_addr"}, 32'(bus.sti_addr), 0);
    chk({tag, "_valid"},    32'(bus.pix_valid), 0);
    chk({tag, "_data"},     32'(bus.pix_data), 0);
    chk({tag, "_row"},      32'(bus.pix_row), 0);
    chk({tag, "_col"},      32'(bus.pix_col), 0);
    chk({tag, "_sof"},      32'(bus.pix_sof), 0);
    chk({tag, "_eof"},      32'(bus.pix_eof), 0);
  endtask

  task automatic load_rom(input int pat);
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        0:       rom[i] = 16'hFFFF;
        1:       rom[i] = 16'h0000;
        2:       rom[i] = 16'($urandom);
        default: rom[i] = rom[i];
      endcase
    end
    if (pat == 1) begin
      rom[0] = 16'h8001;
      rom[8] = 16'h4000;
    end
  endtask

  // Reference unpack: word = row*8 + col/16, MSB is the leftmost pixel.
  task automatic fill_expected();
    logic [15:0] w;
    pix_t p;
    exp_q.delete();
    for (int idx = 0; idx < 16384; idx++) begin
      w     = rom[(idx / 128) * 8 + (idx % 128) / 16];
      p.d   = w[15 - (idx % 16)];
      p.r   = 7'(idx / 128);
      p.c   = 7'(idx % 128);
      p.sof = (idx == 0);
      p.eof = (idx == 16383);
      exp_q.push_back(p);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: request captured at the falling edge, data sampled at the next rising edge.
  initial bus.sti_di = '0;
  always @(negedge clk) if (bus.sti_rd) bus.sti_di <= rom[bus.sti_addr];

  // Consumer ready pattern, updated just after each rising edge.
  initial begin
    int ph;
    ph = 0;
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) bus.pix_ready = 1'b1;
      else begin
        bus.pix_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // Monitor: address order, buffer bound, stall stability, scoreboard, done timing.
  always @(negedge clk) begin
    pix_t cur;
    pix_t e;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      cur = {bus.pix_data, bus.pix_row, bus.pix_col, bus.pix_sof, bus.pix_eof};
      if (bus.sti_rd) begin
        chk("rd_addr", 32'(bus.sti_addr), 32'(exp_addr));
        exp_addr++;
        rd_cnt++;
      end
      chk("buffer_le2", 32'(rd_cnt - acc_cnt / 16 <= 2), 1);
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.pix_valid), 1);
        chk("stall_hold", 32'(cur), 32'(prev_pix));
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pixel_extra: got pixel 0x%0h expected none (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 32'(cur), 32'(e));
        end
        if (acc_cnt == 0) first_acc_edge = cyc + 1;
        last_acc_edge = cyc + 1;
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 32'(cyc), 32'(last_acc_edge));
        chk("busy_at_done", 32'(busy), 0);
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_pix   = cur;
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    bit p1, p2, fin;
    int e0;
    p1 = 0; p2 = 0; fin = 0;
    if (!v.b2b) begin
      repeat (3) @(posedge clk);
      #1;
    end
    load_rom(v.pat);
    fill_expected();
    rdy_mode       = v.rdy;
    acc_cnt        = 0;
    rd_cnt         = 0;
    done_cnt       = 0;
    exp_addr       = 0;
    first_acc_edge = -1;
    last_acc_edge  = -1;
    start = 1'b1;
    e0    = cyc + 1;
    for (int unsigned k = 0; k < 60000; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_cnt > 0) begin fin = 1; break; end
      if (v.abort_at > 0 && acc_cnt >= v.abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        exp_q.delete();
        fin = 1;
        break;
      end
      if (v.repulse && !p1 && acc_cnt >= 100) begin start = 1'b1; p1 = 1; end
      else if (v.repulse && !p2 && acc_cnt >= 16000) begin start = 1'b1; p2 = 1; end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL vec%0d_timeout: got %0d accepted expected frame end", id, acc_cnt);
    end
    chk("accepted", 32'(acc_cnt), 32'(v.exp_acc));
    chk("done_pulses", 32'(done_cnt), 32'(v.exp_done));
    if (v.exp_rd >= 0)    chk("rd_cycles", 32'(rd_cnt), 32'(v.exp_rd));
    if (v.exp_first >= 0) chk("first_accept", 32'(first_acc_edge - e0), 32'(v.exp_first));
    if (v.abort_at == 0)  chk("sb_left", 32'(exp_q.size()), 0);
    if (v.abort_at > 0) begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    //          pat rdy rep b2b abort exp_acc exp_rd done first
    vecs[0] = '{0,  1,  0,  0,  0,    16384,  1024,  1,   2};
    vecs[1] = '{1,  1,  1,  0,  0,    16384,  1024,  1,   2};
    vecs[2] = '{2,  3,  0,  1,  5000, 5000,   -1,    0,   -1};
    vecs[3] = '{3,  1,  0,  0,  0,    16384,  1024,  1,   2};

    #1 rst_n = 1'b0;
    #2 check_reset("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    repeat (5) @(posedge clk);
    #1;
    chk("tail_busy", 32'(busy), 0);
    chk("tail_valid", 32'(bus.pix_valid), 0);
    chk("tail_done", 32'(done), 0);
    chk("tail_done_pulses", 32'(done_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
